karatsuba_seq: RTL



---
 rtl/karatsuba_pkg.sv | 21 ++
 rtl/shift_add_mul.sv | 45 ++++
 rtl/karatsuba_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: state encoding and width/latency helpers shared by the Karatsuba multiplier
package karatsuba_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREP    = 3'd1,
        S_MUL_LL  = 3'd2,
        S_MUL_HH  = 3'd3,
        S_MUL_M   = 3'd4,
        S_COMBINE = 3'd5,
        S_DONE    = 3'd6
    } state_t;
    function automatic int half_w(input int w);
        return w / 2;
    endfunction
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction
    function automatic int latency(input int w);
        return 3 * (w / 2 + 1) + 2;
    endfunction
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: W-cycle unsigned shift-add multiplier, done pulses the cycle after the last step
module shift_add_mul #(
    parameter int W = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] p
);
    localparam int CW = $clog2(W + 1);
    logic [2*W-1:0] mc;
    logic [W-1:0]   mp;
    logic [CW-1:0]  cnt;
    logic           run;
    // first partial product is folded into the start cycle so the whole product takes exactly W edges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p    <= '0;
            mc   <= '0;
            mp   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            p    <= b[0] ? {{W{1'b0}}, a} : '0;
            mc   <= {{(W-1){1'b0}}, a, 1'b0};
            mp   <= b >> 1;
            cnt  <= CW'(W - 1);
            run  <= 1'b1;
            done <= 1'b0;
        end else if (run) begin
            p    <= p + (mp[0] ? mc : '0);
            mc   <= mc << 1;
            mp   <= mp >> 1;
            cnt  <= cnt - 1'b1;
            run  <= cnt != CW'(1);
            done <= cnt == CW'(1);
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/karatsuba_seq.sv
// karatsuba_seq: multi-cycle signed/unsigned Karatsuba multiplier sharing one shift-add sub-multiplier
module karatsuba_seq import karatsuba_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Z,
    output logic               busy
);
    localparam int H  = half_w(WIDTH);
    localparam int PW = prod_w(WIDTH);
    localparam int W1 = H + 1;
    localparam int CW = $clog2(H + 2);
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] x_r, y_r, mx, my;
    logic            sm_r, neg;
    logic [2*W1-1:0] pll, phh, p, mid;
    logic [W1-1:0]   ma, mb;
    logic [PW-1:0]   mag;
    logic            start, mdone, mul_st, last;
    // next state and handshake outputs; each MUL phase lasts H+1 cycles
    always_comb begin
        state_nxt = state;
        mul_st    = state inside {S_MUL_LL, S_MUL_HH, S_MUL_M};
        last      = cnt == CW'(H);
        start     = mul_st && cnt == '0;
        in_ready  = state == S_IDLE;
        busy      = state != S_IDLE;
        out_valid = state == S_DONE;
        case (state)
            S_IDLE:    if (in_valid) state_nxt = S_PREP;
            S_PREP:    state_nxt = S_MUL_LL;
            S_MUL_LL:  if (last) state_nxt = S_MUL_HH;
            S_MUL_HH:  if (last) state_nxt = S_MUL_M;
            S_MUL_M:   if (last) state_nxt = S_COMBINE;
            S_COMBINE: state_nxt = S_DONE;
            S_DONE:    if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end
    // state register and per-phase cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (mul_st && !last) ? cnt + 1'b1 : '0;
        end
    end
    // operand mux for the shared sub-multiplier and the final recombination
    always_comb begin
        ma  = (state == S_MUL_LL) ? W1'(mx[H-1:0]) :
              (state == S_MUL_HH) ? W1'(mx[WIDTH-1:H]) : W1'(mx[WIDTH-1:H]) + W1'(mx[H-1:0]);
        mb  = (state == S_MUL_LL) ? W1'(my[H-1:0]) :
              (state == S_MUL_HH) ? W1'(my[WIDTH-1:H]) : W1'(my[WIDTH-1:H]) + W1'(my[H-1:0]);
        mid = p - phh - pll;
        mag = (PW'(phh) << WIDTH) + (PW'(mid) << H) + PW'(pll);
    end
    shift_add_mul #(.W(W1)) u_mul (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (ma),
        .b     (mb),
        .done  (mdone),
        .p     (p)
    );
    // operand capture, magnitude prep, partial-product capture (done lands one cycle into the next phase) and result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_r  <= '0;
            y_r  <= '0;
            sm_r <= 1'b0;
            mx   <= '0;
            my   <= '0;
            neg  <= 1'b0;
            pll  <= '0;
            phh  <= '0;
            Z    <= '0;
        end else begin
            if (in_valid && state == S_IDLE) begin
                x_r  <= X;
                y_r  <= Y;
                sm_r <= SIGNED_EN && signed_mode;
            end
            if (state == S_PREP) begin
                mx  <= (sm_r && x_r[WIDTH-1]) ? -x_r : x_r;
                my  <= (sm_r && y_r[WIDTH-1]) ? -y_r : y_r;
                neg <= sm_r && (x_r[WIDTH-1] ^ y_r[WIDTH-1]);
            end
            if (mdone && state == S_MUL_HH) pll <= p;
            if (mdone && state == S_MUL_M) phh <= p;
            if (state == S_COMBINE) Z <= neg ? -mag : mag;
        end
    end
endmodule
